// File: rtl/id_ex_operand_stage_if.sv
// ID/EX stage bundle: decoded operands from ID, producer info from EX/MEM and MEM/WB,
// and the forwarded operands and control presented to the ALU and EX/MEM.
interface id_ex_operand_stage_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CTRL_W = 4
);
  logic              stall;
  logic              flush;
  logic              id_valid;
  logic [DATA_W-1:0] id_read_data_1;
  logic [DATA_W-1:0] id_read_data_2;
  logic [DATA_W-1:0] id_imm;
  logic              id_alu_src;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic [REG_AW-1:0] id_rd;
  logic              id_reg_write;
  logic [CTRL_W-1:0] id_alu_control;
  logic              exmem_reg_write;
  logic [REG_AW-1:0] exmem_rd;
  logic [DATA_W-1:0] exmem_alu_result;
  logic              memwb_reg_write;
  logic [REG_AW-1:0] memwb_rd;
  logic [DATA_W-1:0] memwb_write_data;
  logic              ex_valid;
  logic [DATA_W-1:0] Read_data_1;
  logic [DATA_W-1:0] Read_data_2;
  logic [CTRL_W-1:0] ALUControl;
  logic [DATA_W-1:0] ex_store_data;
  logic [REG_AW-1:0] ex_rd;
  logic              ex_reg_write;
  logic [1:0]        fwd_a;
  logic [1:0]        fwd_b;

  modport master (
    output stall, flush, id_valid, id_read_data_1, id_read_data_2, id_imm, id_alu_src,
           id_rs, id_rt, id_rd, id_reg_write, id_alu_control,
           exmem_reg_write, exmem_rd, exmem_alu_result,
           memwb_reg_write, memwb_rd, memwb_write_data,
    input  ex_valid, Read_data_1, Read_data_2, ALUControl, ex_store_data, ex_rd,
           ex_reg_write, fwd_a, fwd_b
  );

  modport slave (
    input  stall, flush, id_valid, id_read_data_1, id_read_data_2, id_imm, id_alu_src,
           id_rs, id_rt, id_rd, id_reg_write, id_alu_control,
           exmem_reg_write, exmem_rd, exmem_alu_result,
           memwb_reg_write, memwb_rd, memwb_write_data,
    output ex_valid, Read_data_1, Read_data_2, ALUControl, ex_store_data, ex_rd,
           ex_reg_write, fwd_a, fwd_b
  );
endinterface

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with combinational RAW forwarding from EX/MEM and MEM/WB.
// Operand outputs feed the ALU directly; destination/write-enable continue to EX/MEM.
module id_ex_operand_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CTRL_W = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  id_ex_operand_stage_if.slave bus
);

  logic              valid_q;
  logic              reg_write_q;
  logic [CTRL_W-1:0] alu_ctrl_q;
  logic [REG_AW-1:0] rs_q;
  logic [REG_AW-1:0] rt_q;
  logic [REG_AW-1:0] rd_q;
  logic [DATA_W-1:0] rd1_q;
  logic [DATA_W-1:0] rd2_q;
  logic [DATA_W-1:0] imm_q;
  logic              alu_src_q;

  // Flush beats stall so a squashed instruction never lingers in EX.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q     <= 1'b0;
      reg_write_q <= 1'b0;
      alu_ctrl_q  <= '0;
      rs_q        <= '0;
      rt_q        <= '0;
      rd_q        <= '0;
      rd1_q       <= '0;
      rd2_q       <= '0;
      imm_q       <= '0;
      alu_src_q   <= 1'b0;
    end else if (bus.flush) begin
      valid_q     <= 1'b0;
      reg_write_q <= 1'b0;
      alu_ctrl_q  <= '0;
      rs_q        <= '0;
      rt_q        <= '0;
      rd_q        <= '0;
      rd1_q       <= '0;
      rd2_q       <= '0;
      imm_q       <= '0;
      alu_src_q   <= 1'b0;
    end else if (!bus.stall) begin
      valid_q     <= bus.id_valid;
      reg_write_q <= bus.id_reg_write & bus.id_valid;
      alu_ctrl_q  <= bus.id_alu_control;
      rs_q        <= bus.id_rs;
      rt_q        <= bus.id_rt;
      rd_q        <= bus.id_rd;
      rd1_q       <= bus.id_read_data_1;
      rd2_q       <= bus.id_read_data_2;
      imm_q       <= bus.id_imm;
      alu_src_q   <= bus.id_alu_src;
    end
  end

  // Youngest producer wins; $zero is never a forwarding target.
  function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] src,
                                         input logic              em_we,
                                         input logic [REG_AW-1:0] em_rd,
                                         input logic              mw_we,
                                         input logic [REG_AW-1:0] mw_rd);
    if (em_we && (em_rd != '0) && (em_rd == src)) begin
      return 2'b10;
    end else if (mw_we && (mw_rd != '0) && (mw_rd == src)) begin
      return 2'b01;
    end
    return 2'b00;
  endfunction

  logic [1:0]        fwd_a_sel;
  logic [1:0]        fwd_b_sel;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_rt;

  always_comb begin
    fwd_a_sel = fwd_sel(rs_q, bus.exmem_reg_write, bus.exmem_rd,
                        bus.memwb_reg_write, bus.memwb_rd);
    fwd_b_sel = fwd_sel(rt_q, bus.exmem_reg_write, bus.exmem_rd,
                        bus.memwb_reg_write, bus.memwb_rd);

    case (fwd_a_sel)
      2'b10:   op_a = bus.exmem_alu_result;
      2'b01:   op_a = bus.memwb_write_data;
      default: op_a = rd1_q;
    endcase

    case (fwd_b_sel)
      2'b10:   op_rt = bus.exmem_alu_result;
      2'b01:   op_rt = bus.memwb_write_data;
      default: op_rt = rd2_q;
    endcase
  end

  assign bus.ex_valid      = valid_q;
  assign bus.ex_reg_write  = reg_write_q & valid_q;
  assign bus.ALUControl    = alu_ctrl_q;
  assign bus.ex_rd         = rd_q;
  assign bus.Read_data_1   = op_a;
  assign bus.ex_store_data = op_rt;
  // fwd_b still reports the rt hazard under alu_src so stores get their data.
  assign bus.Read_data_2   = alu_src_q ? imm_q : op_rt;
  assign bus.fwd_a         = fwd_a_sel;
  assign bus.fwd_b         = fwd_b_sel;

endmodule

// File: doc/id_ex_operand_stage.md
Name: id_ex_operand_stage

Overview:
- ID/EX pipeline register and operand-forwarding stage for the 5-stage MIPS-32 core.
- Captures decoded operands and control from ID, resolves RAW hazards from EX/MEM and MEM/WB, and presents final operands and ALU control to the ALU.
- Output ports Read_data_1, Read_data_2 and ALUControl connect directly to the ALU.
- Also carries destination and write-enable information downstream to EX/MEM.

Parameters:
- DATA_W, 32, datapath width.
- REG_AW, 5, register-index width.
- CTRL_W, 4, ALU control width.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- stall  input  1  hold current contents.
- flush  input  1  replace captured instruction with a bubble.
- id_valid  input  1  ID holds a real instruction.
- id_read_data_1  input  DATA_W  register-file rs value.
- id_read_data_2  input  DATA_W  register-file rt value.
- id_imm  input  DATA_W  sign-extended immediate.
- id_alu_src  input  1  1 = operand 2 is the immediate.
- id_rs  input  REG_AW  source register 1 index.
- id_rt  input  REG_AW  source register 2 index.
- id_rd  input  REG_AW  destination index, already muxed by ID.
- id_reg_write  input  1  instruction writes the register file.
- id_alu_control  input  CTRL_W  ALU operation code.
- exmem_reg_write  input  1  EX/MEM instruction writes.
- exmem_rd  input  REG_AW  EX/MEM destination.
- exmem_alu_result  input  DATA_W  EX/MEM result.
- memwb_reg_write  input  1  MEM/WB instruction writes.
- memwb_rd  input  REG_AW  MEM/WB destination.
- memwb_write_data  input  DATA_W  MEM/WB write-back value.
- ex_valid  output  1  EX holds a real instruction.
- Read_data_1  output  DATA_W  final ALU operand A.
- Read_data_2  output  DATA_W  final ALU operand B.
- ALUControl  output  CTRL_W  ALU operation.
- ex_store_data  output  DATA_W  forwarded rt value, for stores.
- ex_rd  output  REG_AW  destination for EX/MEM.
- ex_reg_write  output  1  write enable for EX/MEM; gated by ex_valid.
- fwd_a  output  2  forwarding select, operand A.
- fwd_b  output  2  forwarding select, rt path.

Behaviour:
- Reset (rst_n=0, asynchronous): all internal registers are cleared to 0.
  - ex_valid=0, ex_reg_write=0, ALUControl=4'b0000, ex_rd=0.
  - Read_data_1, Read_data_2 and ex_store_data are 0 at reset because all forwarding sources are assumed idle; they are combinational.
  - Reset asserted mid-operation discards the held instruction immediately.
- Capture, priority per rising edge (highest first):
  - flush=1: bubble. Registers get valid=0, reg_write=0, ALUControl=0, rs=rt=rd=0, data=0. Flush wins over stall.
  - stall=1: all registers hold.
  - Otherwise: capture all id_* inputs. Stored reg_write = id_reg_write & id_valid.
- Latency: one cycle from ID inputs to registered fields. Forwarding and operand muxing are purely combinational from the registered fields and the current EX/MEM and MEM/WB inputs.
- Forwarding select for a source index s (applied to rs → fwd_a and rt → fwd_b):
  - 2'b10 if exmem_reg_write && exmem_rd!=0 && exmem_rd==s.
  - else 2'b01 if memwb_reg_write && memwb_rd!=0 && memwb_rd==s.
  - else 2'b00 (registered register-file value).
  - EX/MEM takes priority over MEM/WB when both match (youngest producer wins).
  - Index 0 never forwards; $zero always reads the registered value.
- Operand outputs:
  - Read_data_1 = forwarded rs value.
  - ex_store_data = forwarded rt value.
  - Read_data_2 = registered immediate if stored alu_src=1, else forwarded rt value.
  - fwd_b still reports the rt hazard when alu_src=1, because stores need it.
- While stalled, forwarding re-evaluates every cycle, so a producer advancing from EX/MEM to MEM/WB is still tracked.
- Bubble outputs: fwd_a = fwd_b = 2'b00, because index 0 never forwards.
- The stage performs no arithmetic. Widths pass through unchanged.

Test Plan:
- Reset:
  - Stimulus: rst_n=0 mid-cycle while holding a valid add.
  - Required: ex_valid, ex_reg_write, ALUControl and ex_rd go to 0 immediately, without waiting for clk.
- Plain capture:
  - Stimulus: id rs=3 (data 0x10), rt=4 (data 0x20), ALUControl=4'b0010, alu_src=0; no hazards.
  - Required: next cycle Read_data_1=0x10, Read_data_2=0x20, fwd_a=fwd_b=00.
- Double hazard:
  - Stimulus: captured rs=5; exmem_rd=5 with result 0xAAAA; memwb_rd=5 with data 0xBBBB; both write-enabled.
  - Required: Read_data_1=0xAAAA, fwd_a=10.
  - Then drop exmem_reg_write: Read_data_1=0xBBBB, fwd_a=01.
- $zero:
  - Stimulus: captured rt=0; exmem_rd=0 with write enabled and result 0xFFFF.
  - Required: Read_data_2 = the registered value (0), fwd_b=00.
- Immediate with store hazard:
  - Stimulus: alu_src=1, imm=0x0000_0008, rt=7; exmem_rd=7 with result 0x1234.
  - Required: Read_data_2=0x8, ex_store_data=0x1234, fwd_b=10.
- Stall and flush:
  - Stimulus: stall=1 for 2 cycles while id_* inputs change.
  - Required: registered fields are unchanged.
  - Then stall=1 and flush=1 together: next cycle ex_valid=0, ex_reg_write=0, ALUControl=0.
